// File: rtl/prt_dptx_lnk_sym_enc_if.sv
// Symbol-stream bundle between a link-layer source and the DisplayPort TX symbol encoder.
// The source drives configuration and input symbols; the encoder drives ready and link outputs.
interface prt_dptx_lnk_sym_enc_if;
    logic       CFG_EN_IN;
    logic       CFG_EFM_IN;
    logic       VLD_IN;
    logic       K_IN;
    logic [4:0] SYM_IN;
    logic [7:0] DAT_IN;
    logic       RDY_OUT;
    logic [8:0] LNK_DAT_OUT;
    logic       LNK_VLD_OUT;
    logic       LNK_SR_OUT;
    logic       ERR_OUT;

    modport master (
        output CFG_EN_IN, CFG_EFM_IN, VLD_IN, K_IN, SYM_IN, DAT_IN,
        input  RDY_OUT, LNK_DAT_OUT, LNK_VLD_OUT, LNK_SR_OUT, ERR_OUT
    );

    modport slave (
        input  CFG_EN_IN, CFG_EFM_IN, VLD_IN, K_IN, SYM_IN, DAT_IN,
        output RDY_OUT, LNK_DAT_OUT, LNK_VLD_OUT, LNK_SR_OUT, ERR_OUT
    );
endinterface

// File: rtl/prt_dptx_lnk_sym_enc.sv
// DisplayPort TX link symbol encoder: maps link symbol codes to 9-bit K/D symbols,
// inserts periodic scrambler resets and expands BS into BS-BF-BF-BS in enhanced framing mode.
module prt_dptx_lnk_sym_enc #(
    parameter int P_SR_INTERVAL = 512
) (
    input  logic                  CLK_IN,
    input  logic                  RST_N_IN,
    prt_dptx_lnk_sym_enc_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEQ1 = 2'd1;
    localparam logic [1:0] ST_SEQ2 = 2'd2;
    localparam logic [1:0] ST_SEQ3 = 2'd3;

    localparam logic [8:0] SYM_BS = 9'h1BC;
    localparam logic [8:0] SYM_BE = 9'h1FB;
    localparam logic [8:0] SYM_SS = 9'h15C;
    localparam logic [8:0] SYM_SE = 9'h1FD;
    localparam logic [8:0] SYM_SR = 9'h11C;
    localparam logic [8:0] SYM_FS = 9'h1FE;
    localparam logic [8:0] SYM_FE = 9'h1F7;
    localparam logic [8:0] SYM_BF = 9'h17C;

    localparam logic [8:0] CNT_MASK = 9'(P_SR_INTERVAL - 1);

    logic [1:0] state_q,  state_d;
    logic [8:0] bs_cnt_q, bs_cnt_d;
    logic       x_sr_q,   x_sr_d;
    logic       rdy_q,    rdy_d;
    logic [8:0] dat_q,    dat_d;
    logic       vld_q,    vld_d;
    logic       sr_q,     sr_d;
    logic       err_q,    err_d;

    logic accept;
    logic bs_is_sr;

    assign accept   = bus.VLD_IN && rdy_q;
    assign bs_is_sr = (bs_cnt_q == 9'd0);

    always_comb begin
        state_d  = state_q;
        bs_cnt_d = bs_cnt_q;
        x_sr_d   = x_sr_q;
        dat_d    = 9'h000;
        vld_d    = 1'b0;
        sr_d     = 1'b0;
        err_d    = 1'b0;

        if (!bus.CFG_EN_IN) begin
            state_d  = ST_IDLE;
            bs_cnt_d = 9'd0;
            x_sr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!bus.K_IN) begin
                            dat_d = {1'b0, bus.DAT_IN};
                            vld_d = 1'b1;
                        end else begin
                            case (bus.SYM_IN)
                                5'd0: begin
                                    // The X symbol is remembered so the closing symbol of an
                                    // enhanced-framing sequence repeats the opening one.
                                    x_sr_d   = bs_is_sr;
                                    dat_d    = bs_is_sr ? SYM_SR : SYM_BS;
                                    vld_d    = 1'b1;
                                    sr_d     = bs_is_sr;
                                    bs_cnt_d = (bs_cnt_q + 9'd1) & CNT_MASK;
                                    if (bus.CFG_EFM_IN) begin
                                        state_d = ST_SEQ1;
                                    end
                                end
                                5'd1: begin
                                    dat_d = SYM_BE;
                                    vld_d = 1'b1;
                                end
                                5'd3: begin
                                    dat_d = SYM_SS;
                                    vld_d = 1'b1;
                                end
                                5'd6: begin
                                    dat_d = SYM_SE;
                                    vld_d = 1'b1;
                                end
                                5'd7: begin
                                    dat_d    = SYM_SR;
                                    vld_d    = 1'b1;
                                    sr_d     = 1'b1;
                                    bs_cnt_d = 9'd1;
                                end
                                5'd12: begin
                                    dat_d = SYM_FS;
                                    vld_d = 1'b1;
                                end
                                5'd13: begin
                                    dat_d = SYM_FE;
                                    vld_d = 1'b1;
                                end
                                5'd14: begin
                                    dat_d = SYM_BF;
                                    vld_d = 1'b1;
                                end
                                5'd15: begin
                                    vld_d = 1'b0;
                                end
                                default: begin
                                    err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_SEQ1: begin
                    dat_d   = SYM_BF;
                    vld_d   = 1'b1;
                    state_d = ST_SEQ2;
                end
                ST_SEQ2: begin
                    dat_d   = SYM_BF;
                    vld_d   = 1'b1;
                    state_d = ST_SEQ3;
                end
                ST_SEQ3: begin
                    dat_d   = x_sr_q ? SYM_SR : SYM_BS;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rdy_d = bus.CFG_EN_IN && (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q  <= ST_IDLE;
            bs_cnt_q <= 9'd0;
            x_sr_q   <= 1'b0;
            rdy_q    <= 1'b0;
            dat_q    <= 9'h000;
            vld_q    <= 1'b0;
            sr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bs_cnt_q <= bs_cnt_d;
            x_sr_q   <= x_sr_d;
            rdy_q    <= rdy_d;
            dat_q    <= dat_d;
            vld_q    <= vld_d;
            sr_q     <= sr_d;
            err_q    <= err_d;
        end
    end

    assign bus.RDY_OUT     = rdy_q;
    assign bus.LNK_DAT_OUT = dat_q;
    assign bus.LNK_VLD_OUT = vld_q;
    assign bus.LNK_SR_OUT  = sr_q;
    assign bus.ERR_OUT     = err_q;

endmodule

// File: tb/tb_prt_dptx_lnk_sym_enc.sv
// Self-checking bench for prt_dptx_lnk_sym_enc: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_prt_dptx_lnk_sym_enc;

    localparam int P_SR = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    prt_dptx_lnk_sym_enc_if bus();

    prt_dptx_lnk_sym_enc #(.P_SR_INTERVAL(P_SR)) dut (
        .CLK_IN  (clk),
        .RST_N_IN(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       efm;
        logic       vld;
        logic       k;
        logic [4:0] sym;
        logic [7:0] dat;
        logic [8:0] e_dat;
        logic       e_vld;
        logic       e_sr;
        logic       e_err;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[$];

    // reference model state: pending symbols of an expanded BS, scrambler-reset counter, ready
    logic [8:0] m_q[$];
    int         m_cnt;
    logic       m_rdy;

    task automatic addVec(input logic en, input logic efm, input logic vld, input logic k,
                          input logic [4:0] sym, input logic [7:0] dat, input logic [8:0] e_dat,
                          input logic e_vld, input logic e_sr, input logic e_err, input logic e_rdy);
        vec_t v;
        v.en = en; v.efm = efm; v.vld = vld; v.k = k; v.sym = sym; v.dat = dat;
        v.e_dat = e_dat; v.e_vld = e_vld; v.e_sr = e_sr; v.e_err = e_err; v.e_rdy = e_rdy;
        vecs.push_back(v);
    endtask

    // drive one cycle of inputs, then sample just after the active edge
    task automatic applyStimulus(input logic en, input logic efm, input logic vld, input logic k,
                                 input logic [4:0] sym, input logic [7:0] dat);
        bus.CFG_EN_IN  = en;
        bus.CFG_EFM_IN = efm;
        bus.VLD_IN     = vld;
        bus.K_IN       = k;
        bus.SYM_IN     = sym;
        bus.DAT_IN     = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] e_dat, input logic e_vld,
                               input logic e_sr, input logic e_err, input logic e_rdy,
                               input logic chk_dat);
        logic bad;
        checks++;
        bad = (bus.LNK_VLD_OUT !== e_vld) || (bus.LNK_SR_OUT !== e_sr) ||
              (bus.ERR_OUT !== e_err) || (bus.RDY_OUT !== e_rdy) ||
              (chk_dat && (bus.LNK_DAT_OUT !== e_dat));
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s: got dat=%h vld=%b sr=%b err=%b rdy=%b, expected dat=%h vld=%b sr=%b err=%b rdy=%b",
                     name, bus.LNK_DAT_OUT, bus.LNK_VLD_OUT, bus.LNK_SR_OUT, bus.ERR_OUT,
                     bus.RDY_OUT, e_dat, e_vld, e_sr, e_err, e_rdy);
        end
    endtask

    function automatic logic [8:0] codeSym(input logic [4:0] sym);
        case (sym)
            5'd1:  return 9'h1FB;
            5'd3:  return 9'h15C;
            5'd6:  return 9'h1FD;
            5'd12: return 9'h1FE;
            5'd13: return 9'h1F7;
            5'd14: return 9'h17C;
            default: return 9'h000;
        endcase
    endfunction

    task automatic modelStep(input logic en, input logic efm, input logic vld, input logic k,
                             input logic [4:0] sym, input logic [7:0] dat,
                             output logic [8:0] e_dat, output logic e_vld, output logic e_sr,
                             output logic e_err);
        logic [8:0] x;
        e_dat = 9'h000; e_vld = 1'b0; e_sr = 1'b0; e_err = 1'b0;
        if (!en) begin
            m_q.delete();
            m_cnt = 0;
        end else if (m_q.size() > 0) begin
            e_dat = m_q.pop_front();
            e_vld = 1'b1;
        end else if (vld && m_rdy) begin
            if (!k) begin
                e_dat = {1'b0, dat};
                e_vld = 1'b1;
            end else if (sym == 5'd0) begin
                x     = (m_cnt == 0) ? 9'h11C : 9'h1BC;
                e_sr  = (m_cnt == 0);
                e_dat = x;
                e_vld = 1'b1;
                m_cnt = (m_cnt + 1) % P_SR;
                if (efm) begin
                    m_q.push_back(9'h17C);
                    m_q.push_back(9'h17C);
                    m_q.push_back(x);
                end
            end else if (sym == 5'd7) begin
                e_dat = 9'h11C;
                e_vld = 1'b1;
                e_sr  = 1'b1;
                m_cnt = 1;
            end else if (sym == 5'd15) begin
                e_vld = 1'b0;
            end else if (sym == 5'd2 || sym == 5'd4 || sym == 5'd5 || (sym >= 5'd8 && sym <= 5'd11)) begin
                e_err = 1'b1;
            end else begin
                e_dat = codeSym(sym);
                e_vld = 1'b1;
            end
        end
        m_rdy = en && (m_q.size() == 0);
    endtask

    initial begin
        logic [8:0] e_dat;
        logic       e_vld, e_sr, e_err;
        logic       r_en, r_efm, r_vld, r_k;
        logic [4:0] r_sym;
        logic [7:0] r_dat;

        bus.CFG_EN_IN = 1'b0; bus.CFG_EFM_IN = 1'b0; bus.VLD_IN = 1'b0;
        bus.K_IN = 1'b0; bus.SYM_IN = 5'd0; bus.DAT_IN = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;

        //      en   efm  vld  k    sym    dat     e_dat   vld  sr   err  rdy
        addVec(1'b0,1'b0,1'b0,1'b0,5'd0, 8'h00, 9'h000,1'b0,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b0,1'b0,1'b0,5'd0, 8'h00, 9'h000,1'b0,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b0,5'd0, 8'hA5, 9'h0A5,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd1, 8'h00, 9'h1FB,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd0, 8'h00, 9'h11C,1'b1,1'b1,1'b0,1'b1);
        addVec(1'b0,1'b0,1'b0,1'b0,5'd0, 8'h00, 9'h000,1'b0,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b1,1'b0,1'b0,5'd0, 8'h00, 9'h000,1'b0,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b1,1'b1,1'b1,5'd0, 8'h00, 9'h11C,1'b1,1'b1,1'b0,1'b0);
        addVec(1'b1,1'b0,1'b1,1'b0,5'd0, 8'h3C, 9'h17C,1'b1,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b0,1'b1,1'b0,5'd0, 8'h3C, 9'h17C,1'b1,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b0,1'b1,1'b0,5'd0, 8'h3C, 9'h11C,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b0,5'd0, 8'h3C, 9'h03C,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b1,1'b1,1'b1,5'd0, 8'h00, 9'h1BC,1'b1,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b1,1'b0,1'b0,5'd0, 8'h00, 9'h17C,1'b1,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b1,1'b0,1'b0,5'd0, 8'h00, 9'h17C,1'b1,1'b0,1'b0,1'b0);
        addVec(1'b1,1'b1,1'b0,1'b0,5'd0, 8'h00, 9'h1BC,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd5, 8'h00, 9'h000,1'b0,1'b0,1'b1,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd9, 8'h00, 9'h000,1'b0,1'b0,1'b1,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd15,8'h00, 9'h000,1'b0,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b0,1'b1,5'd1, 8'h00, 9'h000,1'b0,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd7, 8'h00, 9'h11C,1'b1,1'b1,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd0, 8'h00, 9'h1BC,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd14,8'h00, 9'h17C,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd3, 8'h00, 9'h15C,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd6, 8'h00, 9'h1FD,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd12,8'h00, 9'h1FE,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd13,8'h00, 9'h1F7,1'b1,1'b0,1'b0,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd2, 8'h00, 9'h000,1'b0,1'b0,1'b1,1'b1);
        addVec(1'b1,1'b0,1'b1,1'b1,5'd4, 8'h00, 9'h000,1'b0,1'b0,1'b1,1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].efm, vecs[i].vld, vecs[i].k, vecs[i].sym, vecs[i].dat);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_dat, vecs[i].e_vld, vecs[i].e_sr,
                        vecs[i].e_err, vecs[i].e_rdy, vecs[i].e_vld || !vecs[i].en);
        end

        // scrambler-reset interval: BS #1 and #(P_SR+1) become SR
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        for (int i = 0; i <= P_SR; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 8'h00);
            if (i == 0 || i == P_SR)
                checkOutput($sformatf("bs_wrap%0d", i), 9'h11C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            else
                checkOutput($sformatf("bs_wrap%0d", i), 9'h1BC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        end

        // asynchronous reset while the BF-BF part of a sequence is in flight
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 8'h00);
        checkOutput("rst_x1", 9'h11C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("rst_bf1", 9'h17C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rst_hold", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("rst_rdy", 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 8'h00);
        checkOutput("rst_first_bs", 9'h11C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // randomized traffic against the reference model, starting from a clear
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        m_q.delete();
        m_cnt = 0;
        m_rdy = 1'b0;
        checkOutput("rand_sync", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            r_en  = ($urandom_range(0, 99) >= 2);
            r_efm = 1'($urandom_range(0, 1));
            r_vld = ($urandom_range(0, 99) < 75);
            r_k   = 1'($urandom_range(0, 1));
            r_sym = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 15));
            r_dat = 8'($urandom);
            modelStep(r_en, r_efm, r_vld, r_k, r_sym, r_dat, e_dat, e_vld, e_sr, e_err);
            applyStimulus(r_en, r_efm, r_vld, r_k, r_sym, r_dat);
            checkOutput($sformatf("rand%0d", c), e_dat, e_vld, e_sr, e_err, m_rdy, e_vld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prt_dptx_lnk_sym_enc.md
PRT_DPTX_LNK_SYM_ENC -- requirements
Module: prt_dptx_lnk_sym_enc

Interface
REQ-001 Parameter P_SR_INTERVAL, default 512, sets the number of accepted BS symbols per scrambler-reset period (power of 2, 2..512).
REQ-002 RST_N_IN  input  1  reset; asynchronous, active-low.
REQ-003 CLK_IN  input  1  link clock; single clock domain.
REQ-004 CFG_EN_IN  input  1  encoder enable; low acts as a synchronous clear.
REQ-005 CFG_EFM_IN  input  1  enhanced framing mode select.
REQ-006 VLD_IN  input  1  input symbol valid.
REQ-007 K_IN  input  1  1 = control symbol taken from SYM_IN; 0 = data byte taken from DAT_IN.
REQ-008 SYM_IN  input  5  TX link symbol code, prt_dp_tx_lnk_sym_wire encoding (0 BS, 1 BE, 3 SS, 4 SF, 6 SE, 7 SR, 8-11 VCPF0-3, 12 FS, 13 FE, 14 BF, 15 NOP).
REQ-009 DAT_IN  input  8  data byte.
REQ-010 RDY_OUT  output  1  encoder ready; the input is accepted when VLD_IN and RDY_OUT are both high in the same cycle.
REQ-011 LNK_DAT_OUT  output  9  link symbol; bit 8 is the K flag and bits 7:0 are the byte.
REQ-012 LNK_VLD_OUT  output  1  LNK_DAT_OUT valid.
REQ-013 LNK_SR_OUT  output  1  scrambler-reset strobe, coincident with the first SR symbol of each emitted SR or SR-BF-BF-SR sequence.
REQ-014 ERR_OUT  output  1  single-cycle pulse flagging an illegal control code.

Function
REQ-015 All outputs SHALL be registered, with a latency of 1 cycle from acceptance to the first output symbol.
REQ-016 An accepted data input (K_IN=0) SHALL emit {1'b0, DAT_IN}.
REQ-017 Accepted control codes SHALL map as follows: BS 0x1BC, BE 0x1FB, SS 0x15C, SE 0x1FD, SR 0x11C, FS 0x1FE, FE 0x1F7, BF 0x17C.
REQ-018 NOP SHALL be consumed with LNK_VLD_OUT=0 on the following cycle.
REQ-019 Codes 2, 4, 5 and 8-11 SHALL be consumed with LNK_VLD_OUT=0, and ERR_OUT SHALL pulse on the following cycle.
REQ-020 The 9-bit BS counter (bs_cnt) SHALL increment modulo P_SR_INTERVAL on every accepted BS.
REQ-021 An accepted BS with bs_cnt==0 SHALL be replaced by SR (0x11C), with LNK_SR_OUT pulsed.
REQ-022 An accepted explicit SR SHALL emit 0x11C, pulse LNK_SR_OUT, and set bs_cnt to 1.
REQ-023 The FSM SHALL have states IDLE, SEQ1, SEQ2 and SEQ3.
REQ-024 IDLE: RDY_OUT=1; a BS accepted with CFG_EFM_IN=1 SHALL emit X (BS or SR per REQ-021) and go to SEQ1.
REQ-025 SEQ1 SHALL emit BF and go to SEQ2; SEQ2 SHALL emit BF and go to SEQ3; SEQ3 SHALL emit X and go to IDLE.
REQ-026 RDY_OUT SHALL be 0 in SEQ1, SEQ2 and SEQ3, so the sequence X-BF-BF-X is contiguous and uninterruptible.
REQ-027 LNK_SR_OUT SHALL pulse on the first X only.
REQ-028 CFG_EFM_IN SHALL be sampled only at BS acceptance; a change mid-sequence SHALL NOT alter the sequence in progress.
REQ-029 With CFG_EFM_IN=0, BS SHALL be a single symbol, and SR replacement SHALL still apply.
REQ-030 A cycle with no acceptance SHALL drive LNK_VLD_OUT=0 and ERR_OUT=0 on the following cycle.
REQ-031 The bs_cnt wrap from P_SR_INTERVAL-1 to 0 SHALL make the next BS an SR.
REQ-032 CFG_EN_IN=0 SHALL, on the next edge, force FSM=IDLE, bs_cnt=0 and RDY_OUT=0, with all other outputs 0; a sequence in progress SHALL be aborted.
REQ-033 After CFG_EN_IN rises, the first accepted BS SHALL become SR.

Reset
REQ-034 On RST_N_IN low, asynchronously: FSM=IDLE, bs_cnt=0, RDY_OUT=0, LNK_DAT_OUT=0x000, LNK_VLD_OUT=0, LNK_SR_OUT=0, ERR_OUT=0.
REQ-035 Deassertion SHALL be used synchronously; RDY_OUT SHALL rise on the first edge with CFG_EN_IN=1.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence immediately, with no residual BF emitted.

Verification
REQ-037 Enable with EFM=0, then accept data 0xA5 then BE -> next two cycles LNK_DAT_OUT=0x0A5 then 0x1FB, LNK_VLD_OUT=1.
REQ-038 EFM=0, 513 BS accepted -> BS #1 and #513 emit 0x11C with LNK_SR_OUT=1; the other 511 emit 0x1BC.
REQ-039 EFM=1, second BS after enable -> 0x1BC, 0x17C, 0x17C, 0x1BC on 4 consecutive cycles; RDY_OUT=0 for 3 cycles; a held-valid data byte emits on the 5th cycle.
REQ-040 EFM=1, first BS after enable -> 0x11C, 0x17C, 0x17C, 0x11C; LNK_SR_OUT high on cycle 1 only.
REQ-041 Codes 5 and 9 accepted -> LNK_VLD_OUT=0 and ERR_OUT=1 for one cycle each; NOP -> LNK_VLD_OUT=0, ERR_OUT=0.
REQ-042 RST_N_IN low during SEQ2 -> outputs 0 in the same cycle; after release and enable, the next BS emits SR.
